// File: rtl/wb_sdrc_arbiter.sv
// Round-robin Wishbone arbiter sharing the SDRAM controller slave port among NUM_M masters.
// Grant is held for a whole wb_cyc; a watchdog aborts transfers the controller never acks.
module wb_sdrc_arbiter #(
  parameter int unsigned NUM_M   = 2,
  parameter int unsigned APP_AW  = 26,
  parameter int unsigned dw      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     sys_clk,
  input  logic                     wb_rst_i,
  input  logic                     sdr_init_done,
  input  logic [NUM_M-1:0]         m_cyc_i,
  input  logic [NUM_M-1:0]         m_stb_i,
  input  logic [NUM_M-1:0]         m_we_i,
  input  logic [3*NUM_M-1:0]       m_cti_i,
  input  logic [NUM_M*dw/8-1:0]    m_sel_i,
  input  logic [NUM_M*APP_AW-1:0]  m_addr_i,
  input  logic [NUM_M*dw-1:0]      m_dat_i,
  output logic [NUM_M-1:0]         m_ack_o,
  output logic [NUM_M-1:0]         m_err_o,
  output logic [dw-1:0]            m_dat_o,
  output logic                     s_cyc_o,
  output logic                     s_stb_o,
  output logic                     s_we_o,
  output logic [2:0]               s_cti_o,
  output logic [dw/8-1:0]          s_sel_o,
  output logic [APP_AW-1:0]        s_addr_o,
  output logic [dw-1:0]            s_dat_o,
  input  logic                     s_ack_i,
  input  logic [dw-1:0]            s_dat_i,
  output logic [NUM_M-1:0]         grant_o,
  output logic                     busy_o
);

  localparam int unsigned SW = dw / 8;
  localparam int unsigned IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_GRANT, ST_ERR} state_t;

  state_t            state, state_nxt;
  logic [NUM_M-1:0]  grant_nxt;
  logic [IW-1:0]     ptr, ptr_nxt;
  logic [CW-1:0]     wd_cnt, wd_nxt;

  logic [NUM_M-1:0]  cand;
  logic              found;
  logic [IW-1:0]     win, idx;

  logic              own_cyc, own_stb, own_we;
  logic [2:0]        own_cti;
  logic [SW-1:0]     own_sel;
  logic [APP_AW-1:0] own_addr;
  logic [dw-1:0]     own_dat;
  logic              in_grant;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] p, input int unsigned k);
    return IW'((32'(p) + k) % NUM_M);
  endfunction

  assign cand = m_cyc_i & m_stb_i;

  // Round-robin scan starting just after the last winner
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = '0;
    for (int unsigned k = 1; k <= NUM_M; k++) begin
      idx = next_idx(ptr, k);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // One-hot owner mux: grant_o has at most one bit set, so OR-reduction selects the owner slice
  always_comb begin
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    own_we   = 1'b0;
    own_cti  = '0;
    own_sel  = '0;
    own_addr = '0;
    own_dat  = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (grant_o[i]) begin
        own_cyc  |= m_cyc_i[i];
        own_stb  |= m_stb_i[i];
        own_we   |= m_we_i[i];
        own_cti  |= m_cti_i[3*i +: 3];
        own_sel  |= m_sel_i[SW*i +: SW];
        own_addr |= m_addr_i[APP_AW*i +: APP_AW];
        own_dat  |= m_dat_i[dw*i +: dw];
      end
    end
  end

  assign in_grant = (state == ST_GRANT);
  assign s_cyc_o  = in_grant & own_cyc;
  assign s_stb_o  = in_grant & own_cyc & own_stb;
  assign s_we_o   = in_grant & own_we;
  assign s_cti_o  = in_grant ? own_cti  : '0;
  assign s_sel_o  = in_grant ? own_sel  : '0;
  assign s_addr_o = in_grant ? own_addr : '0;
  assign s_dat_o  = in_grant ? own_dat  : '0;

  assign m_ack_o  = in_grant ? (grant_o & {NUM_M{s_ack_i}}) : '0;
  assign m_err_o  = (state == ST_ERR) ? grant_o : '0;
  assign m_dat_o  = s_dat_i;
  assign busy_o   = (state == ST_GRANT) || (state == ST_ERR);

  always_ff @(posedge sys_clk) begin
    if (wb_rst_i) begin
      state   <= ST_INIT;
      grant_o <= '0;
      ptr     <= IW'(NUM_M - 1);
      wd_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      grant_o <= grant_nxt;
      ptr     <= ptr_nxt;
      wd_cnt  <= wd_nxt;
    end
  end

  // Next state; the watchdog falls back to zero on any cycle it does not count
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_o;
    ptr_nxt   = ptr;
    wd_nxt    = '0;
    case (state)
      ST_INIT: begin
        if (sdr_init_done) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (found) begin
          state_nxt = ST_GRANT;
          grant_nxt = NUM_M'(1) << win;
          ptr_nxt   = win;
        end
      end
      ST_GRANT: begin
        if (!own_cyc) begin
          state_nxt = ST_IDLE;
          grant_nxt = '0;
        end else if ((TIMEOUT != 0) && s_stb_o && !s_ack_i) begin
          if (wd_cnt == TO_LAST) state_nxt = ST_ERR;
          else                   wd_nxt    = wd_cnt + CW'(1);
        end
      end
      ST_ERR: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
      default: begin
        state_nxt = ST_INIT;
        grant_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_sdrc_arbiter.sv
// Scoreboard bench for wb_sdrc_arbiter: stimulus queues expected grant/ack/err events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_wb_sdrc_arbiter;

  localparam int unsigned NM = 2;
  localparam int unsigned AW = 26;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  localparam logic [1:0] EV_GRANT = 2'd0;
  localparam logic [1:0] EV_ACK   = 2'd1;
  localparam logic [1:0] EV_ERR   = 2'd2;

  typedef struct packed {
    logic [1:0]    kind;
    logic [NM-1:0] val;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              init_done;
  logic [NM-1:0]     m_cyc, m_stb, m_we;
  logic [3*NM-1:0]   m_cti;
  logic [NM*DW/8-1:0] m_sel;
  logic [NM*AW-1:0]  m_addr;
  logic [NM*DW-1:0]  m_dat;
  logic [NM-1:0]     m_ack_o, m_err_o, grant_o;
  logic [DW-1:0]     m_dat_o;
  logic              s_cyc_o, s_stb_o, s_we_o, busy_o;
  logic [2:0]        s_cti_o;
  logic [DW/8-1:0]   s_sel_o;
  logic [AW-1:0]     s_addr_o;
  logic [DW-1:0]     s_dat_o;
  logic              s_ack;
  logic [DW-1:0]     s_dat;

  ev_t            exp_q[$];
  int             n_vec = 0;
  int             n_err = 0;
  bit             mon_en = 1'b0;
  logic [NM-1:0]  prev_grant = '0;
  int             cnt;

  always #5 clk = ~clk;

  wb_sdrc_arbiter #(.NUM_M(NM), .APP_AW(AW), .dw(DW), .TIMEOUT(TO)) dut (
    .sys_clk(clk), .wb_rst_i(rst), .sdr_init_done(init_done),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_cti_i(m_cti),
    .m_sel_i(m_sel), .m_addr_i(m_addr), .m_dat_i(m_dat),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_cti_o(s_cti_o),
    .s_sel_o(s_sel_o), .s_addr_o(s_addr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack), .s_dat_i(s_dat), .grant_o(grant_o), .busy_o(busy_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input logic [1:0] k, input logic [NM-1:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic mon_chk(input logic [1:0] k, input logic [NM-1:0] v);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL event: got kind %0d value %b, expected none at %0t", k, v, $time);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("event kind%0d", e.kind), {k, v}, {e.kind, e.val});
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (grant_o !== prev_grant) begin
        mon_chk(EV_GRANT, grant_o);
        prev_grant = grant_o;
      end
      if (m_ack_o !== '0) mon_chk(EV_ACK, m_ack_o);
      if (m_err_o !== '0) mon_chk(EV_ERR, m_err_o);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int m, input bit on);
    m_cyc[m] = on;
    m_stb[m] = on;
  endtask

  initial begin
    logic [NM-1:0] oh;
    int w;
    rst = 1'b1; init_done = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = 2'b10; m_cti = '0;
    m_sel = 8'hF3;
    m_addr = {26'h2000200, 26'h0000100};
    m_dat  = {32'hB1B1_0001, 32'hA0A0_0000};
    s_ack = 1'b0; s_dat = 32'hCAFE_F00D;
    tick(); tick();
    chk("reset grant", grant_o, 0);
    chk("reset s_cyc/s_stb", {s_cyc_o, s_stb_o}, 0);
    chk("reset busy", busy_o, 0);
    chk("reset ack/err", {m_ack_o, m_err_o}, 0);
    chk("m_dat broadcast", m_dat_o, 32'hCAFE_F00D);

    // Held in INIT while master 0 requests
    rst = 1'b0; mon_en = 1'b1;
    req(0, 1'b1);
    cnt = 0;
    repeat (50) begin
      tick();
      if ({grant_o, s_cyc_o} !== '0) cnt++;
    end
    chk("init hold cycles granted", cnt, 0);
    init_done = 1'b1;
    expect_ev(EV_GRANT, 2'b01);
    tick();
    chk("init +1 s_cyc", s_cyc_o, 0);
    tick();
    chk("init +2 s_cyc", s_cyc_o, 1);
    chk("init +2 grant", grant_o, 2'b01);
    chk("init +2 busy", busy_o, 1);
    expect_ev(EV_ACK, 2'b01);
    s_ack = 1'b1; tick(); s_ack = 1'b0;
    req(0, 1'b0);
    expect_ev(EV_GRANT, 2'b00);
    tick(); tick();
    chk("idle busy", busy_o, 0);

    // Alternation under continuous requests; late init_done drop must be ignored
    init_done = 1'b0;
    req(0, 1'b1); req(1, 1'b1);
    for (int r = 0; r < 4; r++) begin
      w  = (r % 2 == 0) ? 1 : 0;
      oh = NM'(1) << w;
      expect_ev(EV_GRANT, oh);
      expect_ev(EV_ACK, oh);
      expect_ev(EV_GRANT, 2'b00);
      tick();
      s_ack = 1'b1; tick(); s_ack = 1'b0;
      req(w, 1'b0);
      tick();
      if (r < 3) req(w, 1'b1);
      else       req(1, 1'b0);
    end
    tick();
    chk("after alternation grant", grant_o, 0);

    // Master 1 burst with a strobe gap while master 0 waits
    init_done = 1'b1;
    m_cti[5:3] = 3'b010;
    req(0, 1'b1); req(1, 1'b1);
    expect_ev(EV_GRANT, 2'b10);
    tick();
    chk("mux addr", s_addr_o, 26'h2000200);
    chk("mux we/cti", {s_we_o, s_cti_o}, 4'b1010);
    chk("mux sel", s_sel_o, 4'hF);
    chk("mux dat", s_dat_o, 32'hB1B1_0001);
    for (int b = 0; b < 4; b++) begin
      if (b == 3) m_cti[5:3] = 3'b111;
      expect_ev(EV_ACK, 2'b10);
      s_ack = 1'b1; tick(); s_ack = 1'b0;
      if (b == 1) begin
        m_stb[1] = 1'b0;
        #1;
        chk("burst gap s_cyc/s_stb", {s_cyc_o, s_stb_o}, 2'b10);
        tick();
        m_stb[1] = 1'b1;
      end
    end
    req(1, 1'b0); m_cti[5:3] = 3'b000;
    expect_ev(EV_GRANT, 2'b00);
    expect_ev(EV_GRANT, 2'b01);
    tick(); tick();
    expect_ev(EV_ACK, 2'b01);
    s_ack = 1'b1; tick(); s_ack = 1'b0;
    req(0, 1'b0);
    expect_ev(EV_GRANT, 2'b00);
    tick(); tick();

    // Watchdog: controller never acks master 0
    req(0, 1'b1);
    expect_ev(EV_GRANT, 2'b01);
    expect_ev(EV_ERR, 2'b01);
    tick();
    req(1, 1'b1);
    #1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!s_stb_o) break;
      cnt++;
      tick();
    end
    chk("stalled stb cycles", cnt, TO);
    chk("err pulse", m_err_o, 2'b01);
    chk("err busy/s_cyc", {busy_o, s_cyc_o}, 2'b10);
    chk("err grant held", grant_o, 2'b01);
    req(0, 1'b0);
    expect_ev(EV_GRANT, 2'b00);
    expect_ev(EV_GRANT, 2'b10);
    tick();
    chk("err cleared", m_err_o, 0);
    tick();
    expect_ev(EV_ACK, 2'b10);
    s_ack = 1'b1; tick(); s_ack = 1'b0;
    req(1, 1'b0);
    expect_ev(EV_GRANT, 2'b00);
    tick(); tick();

    // Reset during beat 2 of a master 0 burst, then master 0 must win first again
    m_cti[2:0] = 3'b010;
    req(0, 1'b1); req(1, 1'b1);
    expect_ev(EV_GRANT, 2'b01);
    tick();
    expect_ev(EV_ACK, 2'b01);
    s_ack = 1'b1; tick(); s_ack = 1'b0;
    expect_ev(EV_GRANT, 2'b00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_cti[2:0] = 3'b000;
    chk("mid-burst reset s_cyc/s_stb", {s_cyc_o, s_stb_o}, 0);
    chk("mid-burst reset busy/ack", {busy_o, m_ack_o}, 0);
    expect_ev(EV_GRANT, 2'b01);
    tick();
    chk("post reset INIT s_cyc", s_cyc_o, 0);
    tick();
    chk("post reset first winner", grant_o, 2'b01);
    expect_ev(EV_ACK, 2'b01);
    s_ack = 1'b1; tick(); s_ack = 1'b0;
    req(0, 1'b0);
    expect_ev(EV_GRANT, 2'b00);
    expect_ev(EV_GRANT, 2'b10);
    tick(); tick();
    expect_ev(EV_ACK, 2'b10);
    s_ack = 1'b1; tick(); s_ack = 1'b0;
    req(1, 1'b0);
    expect_ev(EV_GRANT, 2'b00);
    tick(); tick();

    // Ack coincident with owner dropping cyc
    req(0, 1'b1);
    expect_ev(EV_GRANT, 2'b01);
    tick();
    expect_ev(EV_ACK, 2'b01);
    expect_ev(EV_GRANT, 2'b00);
    s_ack = 1'b1;
    req(0, 1'b0);
    #1;
    chk("last-beat ack", m_ack_o, 2'b01);
    tick();
    s_ack = 1'b0;
    chk("last-beat grant cleared", grant_o, 0);
    chk("last-beat s_cyc", s_cyc_o, 0);
    tick(); tick();
    chk("no extra transfer", {grant_o, s_cyc_o}, 0);

    tick();
    chk("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
